// File: rtl/mem_access_arbiter.sv
// Two-port (instruction fetch / load-store) sequencer for the unified RAM with range checking.
// Define MEM_ARB_RR_EN to break simultaneous requests round-robin instead of D-over-IF.
module mem_access_arbiter #(
   parameter int DEPTH       = 512,
   parameter int WAIT_STATES = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        ram_read,
   output logic        ram_write,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        busy,
   output logic        grant_d
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   localparam logic [3:0]  LAST_WAIT = 4'(WAIT_STATES);

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        cur_d;
   logic        cur_we;
   logic        pick_d;
   logic        pick_ok;
   logic [31:0] pick_addr;

`ifdef MEM_ARB_RR_EN
   logic        last_d;
`endif

   // Grant choice for the IDLE cycle; the range check covers all 32 address bits.
   always_comb begin
`ifdef MEM_ARB_RR_EN
      pick_d = d_req & (~if_req | ~last_d);
`else
      pick_d = d_req;
`endif
      pick_addr = pick_d ? d_addr : if_addr;
      pick_ok   = pick_addr < DEPTH_W;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         cur_d     <= 1'b0;
         cur_we    <= 1'b0;
         ram_read  <= 1'b0;
         ram_write <= 1'b0;
         ram_addr  <= 32'd0;
         ram_wdata <= 32'd0;
         if_ack    <= 1'b0;
         if_err    <= 1'b0;
         if_rdata  <= 32'd0;
         d_ack     <= 1'b0;
         d_err     <= 1'b0;
         d_rdata   <= 32'd0;
         busy      <= 1'b0;
         grant_d   <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_d    <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (if_req || d_req) begin
                  busy     <= 1'b1;
                  grant_d  <= pick_d;
                  cur_d    <= pick_d;
                  cur_we   <= pick_d & d_we;
                  wait_cnt <= 4'd0;
`ifdef MEM_ARB_RR_EN
                  last_d   <= pick_d;
`endif
                  if (pick_ok) begin
                     state     <= ACCESS;
                     ram_addr  <= pick_addr;
                     ram_read  <= ~(pick_d & d_we);
                     ram_write <= pick_d & d_we;
                     if (pick_d)
                        ram_wdata <= d_wdata;
                  end else begin
                     // Out-of-range addresses never touch the RAM pins.
                     state  <= DONE;
                     if_ack <= ~pick_d;
                     if_err <= ~pick_d;
                     d_ack  <= pick_d;
                     d_err  <= pick_d;
                  end
               end
            end
            ACCESS: begin
               if (wait_cnt == LAST_WAIT) begin
                  state     <= DONE;
                  ram_read  <= 1'b0;
                  ram_write <= 1'b0;
                  if (cur_d) begin
                     d_ack <= 1'b1;
                     if (!cur_we)
                        d_rdata <= ram_rdata;
                  end else begin
                     if_ack   <= 1'b1;
                     if_rdata <= ram_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy   <= 1'b0;
               if_ack <= 1'b0;
               if_err <= 1'b0;
               d_ack  <= 1'b0;
               d_err  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed steps plus random traffic against a
// transaction-level model (shadow memory, per-port latency rule, grant order rule).
`timescale 1ns/1ps
module tb_mem_access_arbiter;

   localparam int DEPTH = 512;
   localparam int WS0   = 0;
   localparam int WS1   = 3;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n;

   // Instance 0: WAIT_STATES = 0
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_ack, if_err, d_ack, d_err;
   logic [31:0] if_rdata, d_rdata;
   logic        ram_read, ram_write, busy, grant_d;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;

   // Instance 1: WAIT_STATES = 3, fetch port only
   logic        if_req1, d_req1, d_we1;
   logic [31:0] if_addr1, d_addr1, d_wdata1;
   logic        if_ack1, if_err1, d_ack1, d_err1;
   logic [31:0] if_rdata1, d_rdata1;
   logic        ram_read1, ram_write1, busy1, grant_d1;
   logic [31:0] ram_addr1, ram_wdata1, ram_rdata1;

   mem_access_arbiter #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) dut (
      .clock(clock), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .grant_d(grant_d)
   );

   mem_access_arbiter #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) dut_ws (
      .clock(clock), .reset_n(reset_n),
      .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_err(if_err1), .if_rdata(if_rdata1),
      .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_ack(d_ack1), .d_err(d_err1), .d_rdata(d_rdata1),
      .ram_read(ram_read1), .ram_write(ram_write1), .ram_addr(ram_addr1),
      .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .busy(busy1), .grant_d(grant_d1)
   );

   // Negedge-sampled RAMs standing in for the real array, plus strobe activity counters.
   logic [31:0] ram0 [DEPTH];
   logic [31:0] ram1 [DEPTH];
   int rd_cnt0 = 0, wr_cnt0 = 0, rd_cnt1 = 0, bad_cnt = 0;

   always @(negedge clock) begin
      if (ram_write) ram0[ram_addr[8:0]] <= ram_wdata;
      if (ram_read)  ram_rdata <= ram0[ram_addr[8:0]];
      if (ram_read)  rd_cnt0 <= rd_cnt0 + 1;
      if (ram_write) wr_cnt0 <= wr_cnt0 + 1;
      if ((ram_read || ram_write) && (ram_addr >= 32'(DEPTH))) bad_cnt <= bad_cnt + 1;
      if (ram_read && ram_write) bad_cnt <= bad_cnt + 1;
      if (ram_read1) ram_rdata1 <= ram1[ram_addr1[8:0]];
      if (ram_read1) rd_cnt1 <= rd_cnt1 + 1;
      if (ram_write1 || ((ram_read1) && (ram_addr1 >= 32'(DEPTH)))) bad_cnt <= bad_cnt + 1;
   end

   // Reference model state
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] m_if_rdata, m_d_rdata;
   bit          m_last_d;

   int tests = 0;
   int failed = 0;

   function automatic logic [31:0] init_word(input int i);
      init_word = (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_if_rdata = 32'd0;
      m_d_rdata  = 32'd0;
      m_last_d   = 1'b1;
   endtask

   // One transaction (or a simultaneous pair) on instance 0, compared against the model.
   task automatic apply_stimulus(input bit do_if, input bit do_d, input bit we,
                                 input logic [31:0] ia, input logic [31:0] da,
                                 input logic [31:0] wd, input string tag);
      bit d_first, serve_d, ok, first_done;
      int exp_if_n, exp_d_n, got_if_n, got_d_n, t, lat, exp_rd, exp_wr, r0, w0;
      logic [31:0] exp_if_data, exp_d_data;
      bit exp_if_err, exp_d_err;
      exp_if_n = -1; exp_d_n = -1; t = 0; exp_rd = 0; exp_wr = 0; first_done = 0;
      exp_if_data = m_if_rdata; exp_d_data = m_d_rdata; exp_if_err = 0; exp_d_err = 0;
      if (do_if && do_d) begin
`ifdef MEM_ARB_RR_EN
         d_first = !m_last_d;
`else
         d_first = 1'b1;
`endif
      end else begin
         d_first = do_d;
      end
      for (int s = 0; s < 2; s++) begin
         serve_d = (s == 0) ? d_first : !d_first;
         if (serve_d ? !do_d : !do_if) continue;
         ok  = serve_d ? (da < 32'(DEPTH)) : (ia < 32'(DEPTH));
         lat = ok ? (2 + WS0) : 1;
         t   = first_done ? (t + 1 + lat) : lat;
         first_done = 1;
         m_last_d = serve_d;
         if (serve_d) begin
            exp_d_n = t; exp_d_err = !ok;
            if (ok && we) begin
               ref_mem[da[8:0]] = wd; exp_wr += WS0 + 1;
            end else if (ok) begin
               m_d_rdata = ref_mem[da[8:0]]; exp_rd += WS0 + 1;
            end
            exp_d_data = m_d_rdata;
         end else begin
            exp_if_n = t; exp_if_err = !ok;
            if (ok) begin
               m_if_rdata = ref_mem[ia[8:0]]; exp_rd += WS0 + 1;
            end
            exp_if_data = m_if_rdata;
         end
      end

      @(posedge clock); #1;
      r0 = rd_cnt0; w0 = wr_cnt0;
      if_req = do_if; if_addr = ia;
      d_req = do_d; d_we = we; d_addr = da; d_wdata = wd;
      @(posedge clock);
      got_if_n = -1; got_d_n = -1;
      for (int n = 1; n <= 40 && ((do_if && got_if_n < 0) || (do_d && got_d_n < 0)); n++) begin
         @(negedge clock);
         if (do_if && if_ack && got_if_n < 0) begin
            got_if_n = n;
            check_output({tag, " if_err"}, 32'(if_err), 32'(exp_if_err));
            check_output({tag, " if_rdata@ack"}, if_rdata, exp_if_data);
            if_req = 1'b0;
         end
         if (do_d && d_ack && got_d_n < 0) begin
            got_d_n = n;
            check_output({tag, " d_err"}, 32'(d_err), 32'(exp_d_err));
            check_output({tag, " d_rdata@ack"}, d_rdata, exp_d_data);
            check_output({tag, " busy@ack"}, 32'(busy), 32'd1);
            d_req = 1'b0;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      if (do_if) check_output({tag, " if latency"}, 32'(got_if_n), 32'(exp_if_n));
      if (do_d)  check_output({tag, " d latency"}, 32'(got_d_n), 32'(exp_d_n));
      check_output({tag, " if_rdata held"}, if_rdata, m_if_rdata);
      check_output({tag, " d_rdata held"}, d_rdata, m_d_rdata);
      check_output({tag, " grant_d"}, 32'(grant_d), 32'(m_last_d));
      check_output({tag, " read cycles"}, 32'(rd_cnt0 - r0), 32'(exp_rd));
      check_output({tag, " write cycles"}, 32'(wr_cnt0 - w0), 32'(exp_wr));
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 7);
      if (r == 0)      rand_addr = 32'(DEPTH) + 32'($urandom_range(0, 1000));
      else if (r == 1) rand_addr = $urandom | 32'h0001_0000;
      else             rand_addr = 32'($urandom_range(0, DEPTH - 1));
   endfunction

   initial begin
      int n1, r1;
      bit kd, ki;
      reset_n = 1'b0;
      if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
      if_req1 = 0; d_req1 = 0; d_we1 = 0; if_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ram0[i] = init_word(i); ram1[i] = init_word(i); ref_mem[i] = init_word(i);
      end
      ram0[0] = 32'h0080_0085; ref_mem[0] = 32'h0080_0085;
      ram0[133] = 32'd16; ref_mem[133] = 32'd16;
      model_reset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_output("reset busy", 32'(busy), 32'd0);
      check_output("reset strobes", {30'd0, ram_read, ram_write}, 32'd0);
      check_output("reset ram_addr", ram_addr, 32'd0);
      check_output("reset acks", {28'd0, if_ack, if_err, d_ack, d_err}, 32'd0);
      check_output("reset rdata", if_rdata | d_rdata, 32'd0);
      check_output("reset grant_d", 32'(grant_d), 32'd0);
      reset_n = 1'b1;

      apply_stimulus(1, 0, 0, 32'd0, 32'd0, 32'd0, "if read 0");
      apply_stimulus(0, 1, 1, 32'd0, 32'd90, 32'd85, "d store 90");
      apply_stimulus(0, 1, 0, 32'd0, 32'd90, 32'd0, "d load 90");
      apply_stimulus(1, 1, 0, 32'd5, 32'd133, 32'd0, "tie");
      apply_stimulus(0, 1, 0, 32'd0, 32'd512, 32'd0, "d load 512");
      apply_stimulus(0, 1, 0, 32'd0, 32'hFFFF_FFFF, 32'd0, "d load ffffffff");
      apply_stimulus(0, 1, 0, 32'd0, 32'd511, 32'd0, "d load 511");
      apply_stimulus(1, 0, 0, 32'd512, 32'd0, 32'd0, "if read 512");
      apply_stimulus(1, 1, 0, 32'd7, 32'd9, 32'd0, "tie 2");

      // Wait-state instance: fetch of 18 holds the read strobe for four cycles.
      @(posedge clock); #1;
      r1 = rd_cnt1; if_req1 = 1'b1; if_addr1 = 32'd18; n1 = -1;
      @(posedge clock);
      for (int n = 1; n <= 40 && n1 < 0; n++) begin
         @(negedge clock);
         if (if_ack1) begin
            n1 = n;
            check_output("ws3 if_rdata", if_rdata1, init_word(18));
            check_output("ws3 if_err", 32'(if_err1), 32'd0);
            if_req1 = 1'b0;
         end
      end
      if_req1 = 1'b0;
      check_output("ws3 latency", 32'(n1), 32'(WS1 + 2));
      check_output("ws3 read cycles", 32'(rd_cnt1 - r1), 32'(WS1 + 1));

      // Reset during the ACCESS cycle of a store: no ack, strobes and busy drop at the reset edge.
      @(posedge clock); #1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd300; d_wdata = 32'hDEAD_BEEF;
      @(posedge clock); #1;
      check_output("abort in access", {30'd0, busy, ram_write}, 32'd3);
      reset_n = 1'b0;
      @(posedge clock); #1;
      d_req = 1'b0;
      check_output("abort strobes", {30'd0, ram_read, ram_write}, 32'd0);
      check_output("abort busy", 32'(busy), 32'd0);
      check_output("abort d_ack", 32'(d_ack), 32'd0);
      @(negedge clock);
      check_output("abort d_ack 2", 32'(d_ack), 32'd0);
      // The RAM sampled the write strobe at the negedge inside ACCESS before reset landed.
      ref_mem[300] = 32'hDEAD_BEEF;
      model_reset();
      @(posedge clock); #1;
      reset_n = 1'b1;
      apply_stimulus(0, 1, 1, 32'd0, 32'd300, 32'h1234_5678, "reissue store");
      apply_stimulus(0, 1, 0, 32'd0, 32'd300, 32'd0, "reissue load");

      for (int i = 0; i < 30; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         ki = (kind != 1);
         kd = (kind != 0);
         apply_stimulus(ki, kd, 1'($urandom_range(0, 1)), rand_addr(), rand_addr(), $urandom,
                        $sformatf("rand %0d", i));
      end

      check_output("ram pins never illegal", 32'(bad_cnt), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
